reimu_shot_pool: RTL and testbench

Parametrised player-shot manager. Holds NSLOT independent bullets in a fixed slot pool. Spawns a bullet at the player position on fire, rate-limited by a cooldown counter, and moves every live bullet upward by SPEED per clk_22 tick. A bullet retires when it leaves the top of the screen or when the collision logic reports a hit. Sits between player-position logic and the renderer/collision blocks.

---
 rtl/reimu_shot_pool.sv | 152 +++++++++++++++
 tb/tb_reimu_shot_pool.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reimu_shot_pool.sv
// Player-shot slot pool: spawns at the player on fire (cooldown-limited) and moves shots up SPEED per tick; REIMU_SHOT_SPREAD_EN spawns twin shots.
// Latency: fire->shot_valid and hit->clear take one edge; no backpressure, fire is dropped while cooling down or with no free slot.
module reimu_shot_pool #(
    parameter int NSLOT     = 4,
    parameter int SPEED     = 20,
    parameter int COOLDOWN  = 3,
    parameter int SPREAD_DX = 8
) (
    input  logic                 clk_22,
    input  logic                 rst,
    input  logic                 fire,
    input  logic [9:0]           reimux,
    input  logic [9:0]           reimuy,
    input  logic [NSLOT-1:0]     hit,
    output logic [10*NSLOT-1:0]  shot_x,
    output logic [10*NSLOT-1:0]  shot_y,
    output logic [NSLOT-1:0]     shot_valid,
    output logic                 spawn_pulse
);
    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(COOLDOWN);
    localparam logic [9:0]    SPEED_V  = 10'(SPEED);

    typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_st_t;

    slot_st_t        st_q [NSLOT];
    slot_st_t        st_d [NSLOT];
    logic [9:0]      x_q  [NSLOT];
    logic [9:0]      x_d  [NSLOT];
    logic [9:0]      y_q  [NSLOT];
    logic [9:0]      y_d  [NSLOT];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            spawn_pulse_q, spawn_pulse_d;

    logic [NSLOT-1:0] lo_sel;
    logic             lo_found;
    logic             spawn;
    logic [9:0]       lo_x;

`ifdef REIMU_SHOT_SPREAD_EN
    logic [NSLOT-1:0] hi_sel;
    logic             hi_found;
    logic [9:0]       hi_x;
    logic [10:0]      hi_sum;

    assign spawn  = fire && (cnt_q == '0) && lo_found && hi_found;
    assign lo_x   = ({1'b0, reimux} < 11'(SPREAD_DX)) ? 10'd0
                                                      : 10'({1'b0, reimux} - 11'(SPREAD_DX));
    assign hi_sum = {1'b0, reimux} + 11'(SPREAD_DX);
    assign hi_x   = hi_sum[10] ? 10'd1023 : hi_sum[9:0];
`else
    localparam int unused_spread_dx = SPREAD_DX;

    assign spawn = fire && (cnt_q == '0) && lo_found;
    assign lo_x  = reimux;
`endif

    // Free-slot search looks only at pre-edge state, so a slot retiring now is not reusable until next edge.
    always_comb begin
        lo_sel   = '0;
        lo_found = 1'b0;
`ifdef REIMU_SHOT_SPREAD_EN
        hi_sel   = '0;
        hi_found = 1'b0;
`endif
        for (int i = 0; i < NSLOT; i++) begin
            if (st_q[i] == IDLE) begin
                if (!lo_found) begin
                    lo_sel[i] = 1'b1;
                    lo_found  = 1'b1;
                end
`ifdef REIMU_SHOT_SPREAD_EN
                else if (!hi_found) begin
                    hi_sel[i] = 1'b1;
                    hi_found  = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            st_d[i] = st_q[i];
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            case (st_q[i])
                FLY: begin
                    if (hit[i] || (y_q[i] < SPEED_V)) begin
                        st_d[i] = IDLE;
                        y_d[i]  = 10'd0;
                    end else begin
                        y_d[i]  = y_q[i] - SPEED_V;
                    end
                end
                default: begin
                    if (spawn && lo_sel[i]) begin
                        st_d[i] = FLY;
                        x_d[i]  = lo_x;
                        y_d[i]  = reimuy;
                    end
`ifdef REIMU_SHOT_SPREAD_EN
                    else if (spawn && hi_sel[i]) begin
                        st_d[i] = FLY;
                        x_d[i]  = hi_x;
                        y_d[i]  = reimuy;
                    end
`endif
                end
            endcase
        end
    end

    always_comb begin
        cnt_d         = cnt_q;
        spawn_pulse_d = spawn;
        if (spawn) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_22) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                st_q[i] <= IDLE;
                x_q[i]  <= 10'd0;
                y_q[i]  <= 10'd0;
            end
            cnt_q         <= '0;
            spawn_pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                st_q[i] <= st_d[i];
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
            end
            cnt_q         <= cnt_d;
            spawn_pulse_q <= spawn_pulse_d;
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_out
        assign shot_x[10*g +: 10] = x_q[g];
        assign shot_y[10*g +: 10] = y_q[g];
        assign shot_valid[g]      = (st_q[g] == FLY);
    end

    assign spawn_pulse = spawn_pulse_q;

endmodule

// File: tb/tb_reimu_shot_pool.sv
// Directed bench for reimu_shot_pool with a rule-level shot model compared every cycle.
module tb_reimu_shot_pool;
    localparam int NSLOT     = 4;
    localparam int SPEED     = 20;
    localparam int COOLDOWN  = 3;
    localparam int SPREAD_DX = 8;
`ifdef REIMU_SHOT_SPREAD_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 1;
`endif

    logic                clk_22;
    logic                rst;
    logic                fire;
    logic [9:0]          reimux;
    logic [9:0]          reimuy;
    logic [NSLOT-1:0]    hit;
    logic [10*NSLOT-1:0] shot_x;
    logic [10*NSLOT-1:0] shot_y;
    logic [NSLOT-1:0]    shot_valid;
    logic                spawn_pulse;

    reimu_shot_pool #(
        .NSLOT(NSLOT), .SPEED(SPEED), .COOLDOWN(COOLDOWN), .SPREAD_DX(SPREAD_DX)
    ) dut (
        .clk_22(clk_22), .rst(rst), .fire(fire), .reimux(reimux), .reimuy(reimuy),
        .hit(hit), .shot_x(shot_x), .shot_y(shot_y), .shot_valid(shot_valid),
        .spawn_pulse(spawn_pulse)
    );

    initial clk_22 = 1'b0;
    always #5 clk_22 = ~clk_22;

    int vec    = 0;
    int miscmp = 0;
    bit chk_en = 0;

    // model state
    int mx [NSLOT];
    int my [NSLOT];
    bit mv [NSLOT];
    int mcnt   = 0;
    bit mpulse = 0;
    int freel [$];
    bit msp;

    task automatic chk(input string nm, input int slot, input int act, input int exp);
        vec++;
        if (act != exp) begin
            miscmp++;
            $display("FAIL %s slot=%0d got %0d expected %0d at %0t", nm, slot, act, exp, $time);
        end
    endtask

    task automatic next();
        @(negedge clk_22);
    endtask

    always @(posedge clk_22) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                mx[i] = 0; my[i] = 0; mv[i] = 0;
            end
            mcnt   = 0;
            mpulse = 0;
        end else begin
            freel = {};
            for (int i = 0; i < NSLOT; i++)
                if (!mv[i]) freel.push_back(i);
            msp = fire && (mcnt == 0) && (freel.size() >= NEED);
            for (int i = 0; i < NSLOT; i++) begin
                if (mv[i]) begin
                    if (hit[i] || my[i] < SPEED) begin
                        mv[i] = 0; my[i] = 0;
                    end else begin
                        my[i] = my[i] - SPEED;
                    end
                end
            end
            if (msp) begin
`ifdef REIMU_SHOT_SPREAD_EN
                mx[freel[0]] = (int'(reimux) - SPREAD_DX < 0) ? 0 : int'(reimux) - SPREAD_DX;
                mx[freel[1]] = (int'(reimux) + SPREAD_DX > 1023) ? 1023 : int'(reimux) + SPREAD_DX;
                my[freel[1]] = int'(reimuy);
                mv[freel[1]] = 1;
`else
                mx[freel[0]] = int'(reimux);
`endif
                my[freel[0]] = int'(reimuy);
                mv[freel[0]] = 1;
                mcnt = COOLDOWN;
            end else if (mcnt > 0) begin
                mcnt = mcnt - 1;
            end
            mpulse = msp;
        end
    end

    always @(negedge clk_22) begin
        if (chk_en) begin
            for (int i = 0; i < NSLOT; i++) begin
                chk("m_x", i, int'(shot_x[10*i +: 10]), mx[i]);
                chk("m_y", i, int'(shot_y[10*i +: 10]), my[i]);
                chk("m_valid", i, int'(shot_valid[i]), int'(mv[i]));
            end
            chk("m_pulse", -1, int'(spawn_pulse), int'(mpulse));
        end
    end

    initial begin
        rst = 1'b1; fire = 1'b0; hit = '0; reimux = '0; reimuy = '0;
        next();
        chk_en = 1;
        next();
`ifndef REIMU_SHOT_SPREAD_EN
        chk("rst_valid", -1, int'(shot_valid), 0);
        chk("rst_pulse", -1, int'(spawn_pulse), 0);

        // fire held: spawns every COOLDOWN+1 edges until the pool fills
        rst = 1'b0; reimux = 10'd320; reimuy = 10'd400; fire = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            next();
            chk("t1_pulse", -1, int'(spawn_pulse), int'(e % 4 == 1));
            if (e == 1) chk("t1_y0_e1", 0, int'(shot_y[9:0]), 400);
            if (e == 2) chk("t1_y0_e2", 0, int'(shot_y[9:0]), 380);
            if (e == 4) chk("t1_valid_e4", -1, int'(shot_valid), 4'b0001);
            if (e == 5) chk("t1_y1_e5", 1, int'(shot_y[19:10]), 400);
            if (e == 16) chk("t1_valid_e16", -1, int'(shot_valid), 4'b1111);
        end

        // pool full, hit frees slot 2, respawn one edge later
        hit = 4'b0100;
        next();
        hit = '0;
        chk("t3_valid_hit", -1, int'(shot_valid), 4'b1011);
        chk("t3_pulse_full", -1, int'(spawn_pulse), 0);
        next();
        chk("t3_valid_resp", -1, int'(shot_valid), 4'b1111);
        chk("t3_x2", 2, int'(shot_x[29:20]), 320);
        chk("t3_y2", 2, int'(shot_y[29:20]), 400);
        chk("t3_pulse_resp", -1, int'(spawn_pulse), 1);

        // off-top retirement from y=30 and from y=40
        fire = 1'b0; rst = 1'b1;
        next();
        rst = 1'b0; reimux = 10'd50; reimuy = 10'd30; fire = 1'b1;
        next();
        fire = 1'b0;
        chk("t2_y30", 0, int'(shot_y[9:0]), 30);
        next();
        chk("t2_y10", 0, int'(shot_y[9:0]), 10);
        next();
        chk("t2_ret_valid", 0, int'(shot_valid[0]), 0);
        chk("t2_ret_y", 0, int'(shot_y[9:0]), 0);
        chk("t2_ret_x", 0, int'(shot_x[9:0]), 50);
        next();
        reimuy = 10'd40; fire = 1'b1;
        next();
        fire = 1'b0;
        chk("t2_y40", 0, int'(shot_y[9:0]), 40);
        next();
        chk("t2_y20", 0, int'(shot_y[9:0]), 20);
        next();
        chk("t2_y0_live", 0, int'(shot_valid[0]), 1);
        chk("t2_y0", 0, int'(shot_y[9:0]), 0);
        next();
        chk("t2_y0_ret", 0, int'(shot_valid[0]), 0);

        // hit coinciding with off-top, hit on idle slot, hit on spawn edge
        rst = 1'b1;
        next();
        rst = 1'b0; reimux = 10'd320; reimuy = 10'd400; fire = 1'b1;
        next();
        fire = 1'b0;
        repeat (3) next();
        reimux = 10'd100; reimuy = 10'd30; fire = 1'b1;
        next();
        fire = 1'b0;
        next();
        hit = 4'b1010;
        next();
        hit = '0;
        chk("t4_valid", -1, int'(shot_valid), 4'b0001);
        chk("t4_x1", 1, int'(shot_x[19:10]), 100);
        chk("t4_y1", 1, int'(shot_y[19:10]), 0);
        chk("t4_y3", 3, int'(shot_y[39:30]), 0);
        chk("t4_y0", 0, int'(shot_y[9:0]), 280);
        next();
        fire = 1'b1; hit = 4'b0010;
        next();
        fire = 1'b0; hit = '0;
        chk("t4_spawn_hit", -1, int'(shot_valid), 4'b0011);

        // reset mid-flight with cooldown running
        rst = 1'b1;
        next();
        rst = 1'b0; reimux = 10'd320; reimuy = 10'd400; fire = 1'b1;
        repeat (10) next();
        chk("t5_pre_valid", -1, int'(shot_valid), 4'b0111);
        rst = 1'b1;
        next();
        chk("t5_valid", -1, int'(shot_valid), 0);
        chk("t5_x", -1, int'(shot_x != '0), 0);
        chk("t5_y", -1, int'(shot_y != '0), 0);
        chk("t5_pulse", -1, int'(spawn_pulse), 0);
        rst = 1'b0;
        next();
        chk("t5_first_valid", -1, int'(shot_valid), 4'b0001);
        chk("t5_first_pulse", -1, int'(spawn_pulse), 1);
        fire = 1'b0;
        next();
`else
        // twin shots with left clamp, then refusal with one free slot
        rst = 1'b0; reimux = 10'd4; reimuy = 10'd300; fire = 1'b1;
        next();
        fire = 1'b0;
        chk("t6_valid", -1, int'(shot_valid), 4'b0011);
        chk("t6_x0", 0, int'(shot_x[9:0]), 0);
        chk("t6_x1", 1, int'(shot_x[19:10]), 12);
        chk("t6_y0", 0, int'(shot_y[9:0]), 300);
        chk("t6_y1", 1, int'(shot_y[19:10]), 300);
        chk("t6_pulse", -1, int'(spawn_pulse), 1);
        repeat (3) next();
        fire = 1'b1;
        next();
        fire = 1'b0;
        chk("t6_full", -1, int'(shot_valid), 4'b1111);
        hit = 4'b1000;
        next();
        hit = '0;
        repeat (2) next();
        fire = 1'b1;
        next();
        chk("t6_one_free_valid", -1, int'(shot_valid), 4'b0111);
        chk("t6_one_free_pulse", -1, int'(spawn_pulse), 0);
        next();
        chk("t6_still_none", -1, int'(shot_valid), 4'b0111);
        fire = 1'b0;
        next();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
